// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one single-port, word-addressed RAM between two requesters:
//   m0 (cpu) and m1 (loader/debug master). Round-robin arbitration with
//   exactly one access in flight. Every access takes three cycles:
//   IDLE (grant) -> ACCESS (RAM enable) -> RESP (ack to the winner).
//
// Configuration macro:
//   MEM_ARB_BURST_EN - when defined, the current owner keeps priority on a
//   tie while it re-requests in the IDLE cycle right after its ack, for up to
//   MAX_BURST consecutive grants. When undefined, ties strictly alternate and
//   the MAX_BURST parameter does not exist.
//
// Parameters:
//   AW         word address width
//   DW         data width
//   MAX_BURST  max consecutive tie-break grants to one owner (burst build only)
//
// Ports:
//   clk                  clock, all state on the rising edge
//   reset                asynchronous active-high reset
//   m0_req/m1_req        request, held with we/addr/wdata until ack
//   m0_we/m1_we          1 = write, 0 = read
//   m0_addr/m1_addr      word address
//   m0_wdata/m1_wdata    write data
//   m0_ack/m1_ack        one-cycle completion pulse
//   m0_rdata/m1_rdata    read data, non-zero only with ack on a read
//   ram_addr/ram_wdata   registered RAM address / write data
//   ram_re/ram_we        registered RAM read / write enables
//   ram_rdata            RAM read data, valid the cycle after ram_re
//   busy                 high whenever an access is in progress
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW = 30,
    parameter int DW = 32
`ifdef MEM_ARB_BURST_EN
    ,
    parameter int MAX_BURST = 4
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_re,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_nextState;

    // r_rrPtr holds the most recent winner; it resets to 1 so m0 wins the
    // first tie.
    logic          r_rrPtr;
    logic          r_owner;
    logic          r_isWrite;
    logic          r_ramRe;
    logic          r_ramWe;
    logic [AW-1:0] r_ramAddr;
    logic [DW-1:0] r_ramWdata;

    logic          w_anyReq;
    logic          w_tieWinner;
    logic          w_winner;
    logic          w_selWe;
    logic [AW-1:0] w_selAddr;
    logic [DW-1:0] w_selWdata;

`ifdef MEM_ARB_BURST_EN
    localparam int            CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    logic [CW-1:0] r_burstCnt;
    logic          r_afterAck;

    // The owner only keeps a tie when it re-requests in the very first IDLE
    // after its own ack and has not yet used up its burst allowance.
    assign w_tieWinner = (r_afterAck && (r_burstCnt < BURST_MAX)) ? r_rrPtr : ~r_rrPtr;

    // r_afterAck marks the IDLE cycle that directly follows RESP. The burst
    // count restarts at 1 whenever ownership changes and saturates so a lone
    // requester is never throttled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burstCnt <= '0;
            r_afterAck <= 1'b0;
        end else begin
            r_afterAck <= (r_state == RESP);
            if ((r_state == IDLE) && w_anyReq) begin
                if (w_winner == r_rrPtr) begin
                    if (r_burstCnt != BURST_MAX) begin
                        r_burstCnt <= r_burstCnt + 1'b1;
                    end
                end else begin
                    r_burstCnt <= CW'(1);
                end
            end
        end
    end
`else
    // Strict alternation: on a tie the master that did not win last time wins.
    assign w_tieWinner = ~r_rrPtr;
`endif

    always_comb begin
        w_anyReq = m0_req | m1_req;
        w_winner = 1'b0;
        if (m0_req && m1_req) begin
            w_winner = w_tieWinner;
        end else if (m1_req) begin
            w_winner = 1'b1;
        end
        w_selWe    = w_winner ? m1_we    : m0_we;
        w_selAddr  = w_winner ? m1_addr  : m0_addr;
        w_selWdata = w_winner ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyReq) w_nextState = ACCESS;
            ACCESS:  w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // The winner's command is latched on the grant so the RAM sees stable
    // registered signals for the whole ACCESS cycle; everything is cleared as
    // ACCESS ends so the RAM-side bus is quiet outside an access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rrPtr    <= 1'b1;
            r_owner    <= 1'b0;
            r_isWrite  <= 1'b0;
            r_ramRe    <= 1'b0;
            r_ramWe    <= 1'b0;
            r_ramAddr  <= '0;
            r_ramWdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_rrPtr    <= w_winner;
                        r_owner    <= w_winner;
                        r_isWrite  <= w_selWe;
                        r_ramRe    <= ~w_selWe;
                        r_ramWe    <= w_selWe;
                        r_ramAddr  <= w_selAddr;
                        r_ramWdata <= w_selWdata;
                    end
                end
                ACCESS: begin
                    r_ramRe    <= 1'b0;
                    r_ramWe    <= 1'b0;
                    r_ramAddr  <= '0;
                    r_ramWdata <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign ram_re    = r_ramRe;
    assign ram_we    = r_ramWe;
    assign ram_addr  = r_ramAddr;
    assign ram_wdata = r_ramWdata;
    assign busy      = (r_state != IDLE);

    // RAM read data arrives during RESP, so it is steered straight to the
    // winner; a write ack and any non-ack cycle return zero data.
    assign m0_ack   = (r_state == RESP) && !r_owner;
    assign m1_ack   = (r_state == RESP) &&  r_owner;
    assign m0_rdata = (m0_ack && !r_isWrite) ? ram_rdata : '0;
    assign m1_rdata = (m1_ack && !r_isWrite) ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Purpose:
//   Self-checking bench for mem_arbiter. A synchronous RAM model sits on the
//   RAM-side ports. A transaction-level reference model predicts, from the
//   arbitration rules alone, which master is granted in which cycle, when
//   the RAM enables and acks appear, and what read data each ack returns.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW    = 30;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;
    logic          m1_req, m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_re, ram_we;
    logic [DW-1:0] ram_rdata;
    logic          busy;

    logic          ramFill;
    logic [DW-1:0] ramArray [0:DEPTH-1];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // Reference model state: timeline of the single access in flight.
    int            grantCycle;
    int            lastAckCycle;
    int            lastWinner;
    int            runLen;
    int            gMaster;
    logic          gWe;
    logic [AW-1:0] gAddr;
    logic [DW-1:0] gWdata;
    logic [DW-1:0] refMem [0:DEPTH-1];
    bit            pend [2];
    bit            allowIssue;
    int            ackOrder [$];

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_re    (ram_re),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] initWord(input int i);
        return (i == 16) ? 32'hDEAD_BEEF : (32'h1000_0000 + DW'(i * 7));
    endfunction

    // Synchronous single-port RAM: read data appears the cycle after ram_re.
    always @(posedge clk) begin
        if (ramFill) begin
            for (int i = 0; i < DEPTH; i++) ramArray[i] <= initWord(i);
        end else begin
            if (ram_we) ramArray[ram_addr[9:0]] <= ram_wdata;
            if (ram_re) ram_rdata <= ramArray[ram_addr[9:0]];
        end
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cycle %0d: observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input int a0, input logic [DW-1:0] d0,
                                 input logic r1, input logic w1, input int a1, input logic [DW-1:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = AW'(a0); m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = AW'(a1); m1_wdata = d1;
    endtask

    task automatic modelReset();
        grantCycle   = -100;
        lastAckCycle = -100;
        lastWinner   = 1;
        runLen       = 0;
        pend[0]      = 1'b0;
        pend[1]      = 1'b0;
    endtask

    // Compare every DUT output with what the timeline says for this cycle.
    task automatic checkWindow();
        bit            inAccess;
        bit            inResp;
        logic [DW-1:0] expRd;
        inAccess = (cyc == grantCycle + 1);
        inResp   = (cyc == grantCycle + 2);
        expRd    = (inResp && !gWe) ? refMem[gAddr[9:0]] : '0;
        checkOutput("busy",   DW'(busy),   DW'(inAccess || inResp));
        checkOutput("ram_re", DW'(ram_re), DW'(inAccess && !gWe));
        checkOutput("ram_we", DW'(ram_we), DW'(inAccess && gWe));
        if (inAccess) begin
            checkOutput("ram_addr", DW'(ram_addr), DW'(gAddr));
            if (gWe) checkOutput("ram_wdata", ram_wdata, gWdata);
        end
        checkOutput("m0_ack",   DW'(m0_ack), DW'(inResp && gMaster == 0));
        checkOutput("m1_ack",   DW'(m1_ack), DW'(inResp && gMaster == 1));
        checkOutput("m0_rdata", m0_rdata, (inResp && gMaster == 0) ? expRd : '0);
        checkOutput("m1_rdata", m1_rdata, (inResp && gMaster == 1) ? expRd : '0);
        if (inResp) begin
            if (gWe) refMem[gAddr[9:0]] = gWdata;
            pend[gMaster] = 1'b0;
            lastAckCycle  = cyc;
            ackOrder.push_back(gMaster);
        end
    endtask

    // A free arbiter grants whoever is requesting; a tie goes to the master
    // that did not win last (or, in burst builds, to the owner while its
    // run is short and it re-requests right after its ack).
    task automatic modelArbitrate();
        int w;
        if (reset) return;
        if ((cyc >= grantCycle + 3) && (m0_req || m1_req)) begin
            if (m0_req && m1_req) begin
`ifdef MEM_ARB_BURST_EN
                w = ((cyc == lastAckCycle + 1) && (runLen < 4)) ? lastWinner : 1 - lastWinner;
`else
                w = 1 - lastWinner;
`endif
            end else begin
                w = m1_req ? 1 : 0;
            end
            runLen     = (w == lastWinner) ? ((runLen < 4) ? runLen + 1 : 4) : 1;
            lastWinner = w;
            grantCycle = cyc;
            gMaster    = w;
            gWe        = w ? m1_we    : m0_we;
            gAddr      = w ? m1_addr  : m0_addr;
            gWdata     = w ? m1_wdata : m0_wdata;
        end
    endtask

    task automatic stepCycle();
        checkWindow();
        modelArbitrate();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Masters with an outstanding request hold it; idle masters may issue.
    task automatic randomDrive();
        if (!pend[0]) begin
            m0_req = 1'b0;
            if (allowIssue && $urandom_range(0, 2) != 0) begin
                pend[0] = 1'b1;
                m0_req = 1'b1; m0_we = 1'($urandom_range(0, 1));
                m0_addr = AW'($urandom_range(0, 31)); m0_wdata = $urandom;
            end
        end
        if (!pend[1]) begin
            m1_req = 1'b0;
            if (allowIssue && $urandom_range(0, 2) != 0) begin
                pend[1] = 1'b1;
                m1_req = 1'b1; m1_we = 1'($urandom_range(0, 1));
                m1_addr = AW'($urandom_range(0, 31)); m1_wdata = $urandom;
            end
        end
    endtask

    initial begin
        int expOrder [4];
        for (int i = 0; i < DEPTH; i++) refMem[i] = initWord(i);
        modelReset();
        reset   = 1'b1;
        ramFill = 1'b1;
        applyStimulus(0, 0, 0, '0, 0, 0, 0, '0);
        #1;
        repeat (3) stepCycle();
        reset   = 1'b0;
        ramFill = 1'b0;
        stepCycle();

        // Test 1: m0 read of the preloaded word at 0x10.
        $display("[TB] test 1: m0 read");
        applyStimulus(1, 0, 'h10, '0, 0, 0, 0, '0);
        stepCycle();
        checkOutput("t1_ram_re", DW'(ram_re), DW'(1'b1));
        checkOutput("t1_ram_addr", DW'(ram_addr), 32'h10);
        stepCycle();
        checkOutput("t1_m0_ack", DW'(m0_ack), DW'(1'b1));
        checkOutput("t1_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        checkOutput("t1_m1_ack", DW'(m1_ack), DW'(1'b0));
        stepCycle();
        m0_req = 1'b0;
        stepCycle();

        // Test 2: m1 write of 1 to 0x100.
        $display("[TB] test 2: m1 write");
        applyStimulus(0, 0, 0, '0, 1, 1, 'h100, 32'h1);
        stepCycle();
        checkOutput("t2_ram_we", DW'(ram_we), DW'(1'b1));
        checkOutput("t2_ram_wdata", ram_wdata, 32'h1);
        stepCycle();
        checkOutput("t2_ram_we_off", DW'(ram_we), DW'(1'b0));
        checkOutput("t2_m1_ack", DW'(m1_ack), DW'(1'b1));
        checkOutput("t2_m1_rdata", m1_rdata, 32'h0);
        stepCycle();
        m1_req = 1'b0;
        stepCycle();

        // Test 3: both masters request continuously from reset.
        $display("[TB] test 3: continuous contention");
        reset = 1'b1;
        modelReset();
        stepCycle();
        reset = 1'b0;
        ackOrder.delete();
        applyStimulus(1, 0, 'h10, '0, 1, 0, 'h100, '0);
        repeat (12) stepCycle();
`ifdef MEM_ARB_BURST_EN
        expOrder = '{0, 0, 0, 0};
`else
        expOrder = '{0, 1, 0, 1};
`endif
        checkOutput("t3_ack_count", DW'(ackOrder.size()), 32'd4);
        for (int i = 0; i < 4 && i < ackOrder.size(); i++) begin
            checkOutput("t3_ack_order", DW'(ackOrder[i]), DW'(expOrder[i]));
        end
        applyStimulus(0, 0, 0, '0, 0, 0, 0, '0);
        repeat (3) stepCycle();

        // Test 4: reset during the ACCESS cycle of an m0 write aborts it.
        $display("[TB] test 4: reset mid-access");
        applyStimulus(1, 1, 'h20, 32'h5555_AAAA, 0, 0, 0, '0);
        stepCycle();
        checkOutput("t4_ram_we_before", DW'(ram_we), DW'(1'b1));
        reset = 1'b1;
        #1;
        checkOutput("t4_ram_we", DW'(ram_we), DW'(1'b0));
        checkOutput("t4_busy", DW'(busy), DW'(1'b0));
        modelReset();
        applyStimulus(0, 0, 0, '0, 0, 0, 0, '0);
        repeat (2) stepCycle();
        reset = 1'b0;
        applyStimulus(1, 0, 'h20, '0, 1, 0, 'h20, '0);
        stepCycle();
        stepCycle();
        checkOutput("t4_first_m0", DW'(m0_ack), DW'(1'b1));
        checkOutput("t4_old_data", m0_rdata, initWord(32));
        stepCycle();
        applyStimulus(0, 0, 0, '0, 0, 0, 0, '0);
        repeat (2) stepCycle();

        // Test 5: m1 asks while m0 is in ACCESS and is served next.
        $display("[TB] test 5: late m1 request");
        applyStimulus(1, 0, 'h30, '0, 0, 0, 0, '0);
        stepCycle();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = AW'('h31); m1_wdata = 32'hCAFE_0031;
        stepCycle();
        stepCycle();
        m0_req = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("t5_m1_ack", DW'(m1_ack), DW'(1'b1));
        stepCycle();
        m1_req = 1'b0;
        repeat (2) stepCycle();

        // Random traffic against the reference model.
        $display("[TB] random phase");
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        allowIssue = 1'b1;
        for (int i = 0; i < 400; i++) begin
            randomDrive();
            stepCycle();
        end
        allowIssue = 1'b0;
        for (int i = 0; i < 8; i++) begin
            randomDrive();
            stepCycle();
        end
        checkOutput("drain_pending", DW'(pend[0] || pend[1]), DW'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
